pw_act_packer: RTL and testbench



---
 rtl/pw_act_packer_if.sv | 28 ++
 rtl/pw_act_packer.sv | 114 +++++++++++
 tb/tb_pw_act_packer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pw_act_packer_if.sv
// Stream-side and layer-side signals of the pointwise-conv activation packer.
// Upstream byte handshake, downstream stall, and the packed vector with its frame position.
interface pw_act_packer_if #(
    parameter int NUM_CH        = 8,
    parameter int ACT_W         = 8,
    parameter int PIX_PER_FRAME = 16
);
    localparam int PIX_W = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;

    logic                      s_valid;
    logic [ACT_W-1:0]          s_data;
    logic                      s_ready;
    logic                      stall;
    logic                      act_valid;
    logic [NUM_CH*ACT_W-1:0]   act_data;
    logic [PIX_W-1:0]          pix_idx;
    logic                      frame_done;

    modport master (
        output s_valid, s_data, stall,
        input  s_ready, act_valid, act_data, pix_idx, frame_done
    );

    modport slave (
        input  s_valid, s_data, stall,
        output s_ready, act_valid, act_data, pix_idx, frame_done
    );
endinterface

// File: rtl/pw_act_packer.sv
// Packs a byte-serial channel stream into one NUM_CH-lane vector per pixel for a pointwise-conv stage.
// Define PW_ACT_PACKER_FLUSH_EN to add a flush input that restarts assembly and the pixel counter.
module pw_act_packer #(
    parameter int NUM_CH        = 8,
    parameter int ACT_W         = 8,
    parameter int PIX_PER_FRAME = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef PW_ACT_PACKER_FLUSH_EN
    input  logic flush,
`endif
    pw_act_packer_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PIX_W = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

    slot_e                          slot_q, slot_d;
    logic [CH_W-1:0]                ch_cnt_q, ch_cnt_d;
    logic                           asm_done_q, asm_done_d;
    logic [PIX_W-1:0]               pix_idx_q, pix_idx_d;
    logic [NUM_CH-1:0][ACT_W-1:0]   lane_q, lane_d;
    logic [NUM_CH*ACT_W-1:0]        slot_data_q, slot_data_d;

    logic flush_w;
    logic s_ready_w;
    logic accept;
    logic last_byte;
    logic complete;
    logic act_valid_w;
    logic xfer;

`ifdef PW_ACT_PACKER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign s_ready_w   = !asm_done_q && !flush_w;
    assign accept      = bus.s_valid && s_ready_w;
    assign last_byte   = (ch_cnt_q == CH_W'(NUM_CH - 1));
    assign complete    = accept && last_byte;
    assign act_valid_w = (slot_q == SLOT_FULL) && !bus.stall;
    // A finished assembly (just completed or held) moves into the slot when the slot is free or draining.
    assign xfer        = (complete || asm_done_q) && ((slot_q == SLOT_EMPTY) || act_valid_w);

    // lane_d already carries the byte being accepted, so a completing vector loads the slot directly.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            assign lane_d[gi] = (accept && (ch_cnt_q == CH_W'(gi))) ? bus.s_data : lane_q[gi];
        end
    endgenerate

    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        asm_done_d  = asm_done_q;
        slot_d      = slot_q;
        slot_data_d = slot_data_q;
        pix_idx_d   = pix_idx_q;

        if (accept) begin
            ch_cnt_d = last_byte ? '0 : ch_cnt_q + CH_W'(1);
        end

        if (xfer) begin
            asm_done_d = 1'b0;
        end else if (complete) begin
            asm_done_d = 1'b1;
        end

        if (xfer) begin
            slot_d      = SLOT_FULL;
            slot_data_d = lane_d;
        end else if (act_valid_w) begin
            slot_d = SLOT_EMPTY;
        end

        if (act_valid_w) begin
            pix_idx_d = (pix_idx_q == PIX_W'(PIX_PER_FRAME - 1)) ? '0 : pix_idx_q + PIX_W'(1);
        end

        if (flush_w) begin
            ch_cnt_d   = '0;
            asm_done_d = 1'b0;
            pix_idx_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= SLOT_EMPTY;
            ch_cnt_q    <= '0;
            asm_done_q  <= 1'b0;
            pix_idx_q   <= '0;
            lane_q      <= '0;
            slot_data_q <= '0;
        end else begin
            slot_q      <= slot_d;
            ch_cnt_q    <= ch_cnt_d;
            asm_done_q  <= asm_done_d;
            pix_idx_q   <= pix_idx_d;
            lane_q      <= lane_d;
            slot_data_q <= slot_data_d;
        end
    end

    assign bus.s_ready    = s_ready_w;
    assign bus.act_valid  = act_valid_w;
    assign bus.act_data   = slot_data_q;
    assign bus.pix_idx    = pix_idx_q;
    assign bus.frame_done = act_valid_w && (pix_idx_q == PIX_W'(PIX_PER_FRAME - 1));
endmodule

// File: tb/tb_pw_act_packer.sv
// Self-checking bench for pw_act_packer: directed timing steps plus a byte/vector scoreboard.
module tb_pw_act_packer;
    localparam int NUM_CH = 8;
    localparam int ACT_W  = 8;
    localparam int PPF    = 16;

    logic clk = 1'b0;
    logic rst;
`ifdef PW_ACT_PACKER_FLUSH_EN
    logic flush;
`endif

    always #5 clk = ~clk;

    pw_act_packer_if #(.NUM_CH(NUM_CH), .ACT_W(ACT_W), .PIX_PER_FRAME(PPF)) bus ();

    pw_act_packer #(.NUM_CH(NUM_CH), .ACT_W(ACT_W), .PIX_PER_FRAME(PPF)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef PW_ACT_PACKER_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  byte_q[$];
    logic [63:0] exp_vec_q[$];
    int          model_pix = 0;
    int          emit_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        bus.stall   = 1'b0;
        rst         = 1'b1;
        byte_q.delete();
        exp_vec_q.delete();
        model_pix = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Reference model: every NUM_CH accepted bytes form one vector, lane 0 = first byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.act_valid) begin
                chk("vec_avail", 64'(exp_vec_q.size() > 0), 64'd1);
                if (exp_vec_q.size() > 0) chk("sb_act_data", bus.act_data, exp_vec_q.pop_front());
                chk("sb_pix_idx", 64'(bus.pix_idx), 64'(model_pix));
                chk("sb_frame_done", 64'(bus.frame_done), 64'(model_pix == PPF - 1));
                model_pix = (model_pix + 1) % PPF;
                emit_cnt++;
            end else begin
                chk("sb_frame_idle", 64'(bus.frame_done), 64'd0);
            end
            if (bus.s_valid && bus.s_ready) begin
                byte_q.push_back(bus.s_data);
                if (byte_q.size() == NUM_CH) begin
                    logic [63:0] v;
                    v = '0;
                    for (int k = 0; k < NUM_CH; k++) v[k*ACT_W +: ACT_W] = byte_q[k];
                    exp_vec_q.push_back(v);
                    byte_q.delete();
                end
            end
`ifdef PW_ACT_PACKER_FLUSH_EN
            if (flush) begin
                byte_q.delete();
                model_pix = 0;
            end
`endif
        end
    end

    initial begin
        int last_c;
        int pulses;
        int e0;
        int r;

        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.stall   = 1'b0;
`ifdef PW_ACT_PACKER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_s_ready",    64'(bus.s_ready),    64'd1);
        chk("rst_act_valid",  64'(bus.act_valid),  64'd0);
        chk("rst_act_data",   bus.act_data,        64'd0);
        chk("rst_pix_idx",    64'(bus.pix_idx),    64'd0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        rst = 1'b0;

        // Single vector latency and packing order
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(i + 1);
            #1;
            chk("t1_ready", 64'(bus.s_ready), 64'd1);
            chk("t1_idle",  64'(bus.act_valid), 64'd0);
            tick();
        end
        bus.s_valid = 1'b0;
        #1;
        chk("t1_act_valid", 64'(bus.act_valid), 64'd1);
        chk("t1_act_data",  bus.act_data, 64'h0807060504030201);
        tick();
        chk("t1_pulse_end", 64'(bus.act_valid), 64'd0);
        chk("t1_pix_idx",   64'(bus.pix_idx),   64'd1);
        $display("t1 single vector done");

        // Full frame of continuous bytes
        do_reset();
        last_c = 0;
        pulses = 0;
        for (int c = 1; c <= 128; c++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            #1;
            chk("t2_ready", 64'(bus.s_ready), 64'd1);
            tick();
            if (bus.act_valid) begin
                pulses++;
                chk("t2_spacing", 64'(c - last_c), 64'd8);
                chk("t2_frame_done", 64'(bus.frame_done), 64'(pulses == 16));
                last_c = c;
            end
        end
        bus.s_valid = 1'b0;
        tick();
        chk("t2_pulses",   64'(pulses), 64'd16);
        chk("t2_pix_wrap", 64'(bus.pix_idx), 64'd0);
        $display("t2 frame of %0d vectors done", pulses);

        // Stall across two vectors, then release
        do_reset();
        bus.stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'h10 + i);
            #1;
            chk("t3_stalled", 64'(bus.act_valid), 64'd0);
            tick();
        end
        bus.s_data = 8'hC0;
        #1;
        chk("t3_ready_low", 64'(bus.s_ready), 64'd0);
        chk("t3_no_valid",  64'(bus.act_valid), 64'd0);
        chk("t3_hold_A",    bus.act_data, 64'h1716151413121110);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_ready_held", 64'(bus.s_ready), 64'd0);
            chk("t3_data_held",  bus.act_data, 64'h1716151413121110);
        end
        bus.s_valid = 1'b0;
        bus.stall   = 1'b0;
        #1;
        chk("t3_emit_A_valid", 64'(bus.act_valid), 64'd1);
        chk("t3_emit_A_data",  bus.act_data, 64'h1716151413121110);
        tick();
        chk("t3_emit_B_valid", 64'(bus.act_valid), 64'd1);
        chk("t3_emit_B_data",  bus.act_data, 64'h1F1E1D1C1B1A1918);
        chk("t3_ready_back",   64'(bus.s_ready), 64'd1);
        tick();
        chk("t3_drained", 64'(bus.act_valid), 64'd0);
        $display("t3 stall release done");

        // Random valid/stall with sign-bit-heavy lane values
        do_reset();
        e0 = emit_cnt;
        for (int c = 0; c < 300; c++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 3));
            case (r)
                0:       bus.s_data = 8'h80;
                1:       bus.s_data = 8'hFF;
                2:       bus.s_data = 8'h7F;
                default: bus.s_data = 8'($urandom);
            endcase
            bus.stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.stall   = 1'b0;
        repeat (4) tick();
        chk("t4_drained", 64'(exp_vec_q.size()), 64'd0);
        $display("t4 random stream done, %0d vectors", emit_cnt - e0);

        // Reset mid-vector discards the partial assembly
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            tick();
        end
        do_reset();
        e0 = emit_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'hA0 + i);
            tick();
        end
        bus.s_valid = 1'b0;
        #1;
        chk("t5_act_valid", 64'(bus.act_valid), 64'd1);
        chk("t5_act_data",  bus.act_data, 64'hA7A6A5A4A3A2A1A0);
        tick();
        chk("t5_one_vector", 64'(emit_cnt - e0), 64'd1);
        $display("t5 reset mid-vector done");

`ifdef PW_ACT_PACKER_FLUSH_EN
        // Flush mid-vector restarts lanes and the pixel counter
        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'($urandom);
            tick();
        end
        flush       = 1'b1;
        bus.s_data  = 8'hEE;
        #1;
        chk("t6_flush_ready", 64'(bus.s_ready), 64'd0);
        tick();
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        chk("t6_pix_cleared", 64'(bus.pix_idx), 64'd0);
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'hB0 + i);
            tick();
        end
        bus.s_valid = 1'b0;
        #1;
        chk("t6_act_valid", 64'(bus.act_valid), 64'd1);
        chk("t6_act_data",  bus.act_data, 64'hB7B6B5B4B3B2B1B0);
        chk("t6_pix_idx",   64'(bus.pix_idx), 64'd0);
        tick();
        $display("t6 flush done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
